bcd_stopwatch: RTL and testbench

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

---
 rtl/stopwatch_pkg.sv | 45 ++++
 rtl/sync_edge.sv | 30 +++
 rtl/bcd_stopwatch.sv | 128 ++++++++++++
 tb/tb_bcd_stopwatch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states, digit width,
// the packed display time and a BCD increment helper.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SEC_HI_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_hi;
        logic [DIGIT_W-1:0] min_lo;
        logic [DIGIT_W-1:0] sec_hi;
        logic [DIGIT_W-1:0] sec_lo;
    } bcd_time_t;

    // Plain ripple-carry BCD increment; the MAX_MIN wrap is handled by the caller.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_lo != DIGIT_MAX) begin
            r.sec_lo = t.sec_lo + 1'b1;
        end else begin
            r.sec_lo = '0;
            if (t.sec_hi != SEC_HI_MAX) begin
                r.sec_hi = t.sec_hi + 1'b1;
            end else begin
                r.sec_hi = '0;
                if (t.min_lo != DIGIT_MAX) begin
                    r.min_lo = t.min_lo + 1'b1;
                end else begin
                    r.min_lo = '0;
                    r.min_hi = (t.min_hi == DIGIT_MAX) ? '0 : t.min_hi + 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
// Chain and history reset to 1 so an input already high at reset release is not an edge.
module sync_edge #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [DEPTH-1:0] chain_q;
    logic             hist_q;
    logic             pulse_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            chain_q <= '1;
            hist_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], din};
            hist_q  <= chain_q[DEPTH-1];
            pulse_q <= chain_q[DEPTH-1] & ~hist_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch with IDLE/RUN/PAUSE control and registered outputs.
// Define BCD_STOPWATCH_LAP_EN to add the lap input that freezes the display.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_MIN     = 59
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_hz_in,
    input  logic       start_stop,
    input  logic       clear,
`ifdef BCD_STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       rollover
);

    localparam logic [DIGIT_W-1:0] MAX_MIN_HI = DIGIT_W'(MAX_MIN / 10);
    localparam logic [DIGIT_W-1:0] MAX_MIN_LO = DIGIT_W'(MAX_MIN % 10);

    logic tick, press, clr;

    sync_edge #(.DEPTH(SYNC_STAGES)) u_tick_sync  (.clock(clock), .reset(reset),
                                                   .din(one_hz_in), .pulse(tick));
    sync_edge #(.DEPTH(SYNC_STAGES)) u_press_sync (.clock(clock), .reset(reset),
                                                   .din(start_stop), .pulse(press));
    sync_edge #(.DEPTH(SYNC_STAGES)) u_clr_sync   (.clock(clock), .reset(reset),
                                                   .din(clear), .pulse(clr));

    state_t    state_q, state_d;
    bcd_time_t cnt_q, cnt_d;
    bcd_time_t disp_q, disp_d;
    logic      running_q, rollover_q, rollover_d;
    logic      at_max;

    assign at_max = (cnt_q.min_hi == MAX_MIN_HI) && (cnt_q.min_lo == MAX_MIN_LO) &&
                    (cnt_q.sec_hi == SEC_HI_MAX) && (cnt_q.sec_lo == DIGIT_MAX);

    // clr beats press and tick; a tick coinciding with press in RUN still counts.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rollover_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE:  if (press) state_d = RUN;
                RUN: begin
                    if (tick) begin
                        if (at_max) begin
                            cnt_d      = '0;
                            rollover_d = 1'b1;
                        end else begin
                            cnt_d = bcd_inc(cnt_q);
                        end
                    end
                    if (press) state_d = PAUSE;
                end
                PAUSE: if (press) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    logic lap_pulse;
    logic freeze_q, freeze_d;

    sync_edge #(.DEPTH(SYNC_STAGES)) u_lap_sync (.clock(clock), .reset(reset),
                                                 .din(lap), .pulse(lap_pulse));

    // A lap edge freezes only from RUN, but a second edge releases in any state.
    always_comb begin
        freeze_d = freeze_q;
        if (clr) begin
            freeze_d = 1'b0;
        end else if (lap_pulse && (freeze_q || state_q == RUN)) begin
            freeze_d = ~freeze_q;
        end
        disp_d = freeze_d ? disp_q : cnt_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= freeze_d;
        end
    end
`else
    always_comb begin
        disp_d = cnt_d;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            disp_q     <= '0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            running_q  <= (state_d == RUN);
            rollover_q <= rollover_d;
        end
    end

    assign sec_lo   = disp_q.sec_lo;
    assign sec_hi   = disp_q.sec_hi;
    assign min_lo   = disp_q.min_lo;
    assign min_hi   = disp_q.min_hi;
    assign running  = running_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch; expected values are queued by the stimulus and
// popped when the outputs are sampled. Lap checks run when BCD_STOPWATCH_LAP_EN is set.
module tb_bcd_stopwatch;

    localparam int SYNC = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       one_hz_in;
    logic       start_stop;
    logic       clear;
`ifdef BCD_STOPWATCH_LAP_EN
    logic       lap;
`endif
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
    logic       running, rollover;

    bcd_stopwatch #(.SYNC_STAGES(SYNC), .MAX_MIN(59)) dut (
        .clock(clock),
        .reset(reset),
        .one_hz_in(one_hz_in),
        .start_stop(start_stop),
        .clear(clear),
`ifdef BCD_STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .sec_lo(sec_lo),
        .sec_hi(sec_hi),
        .min_lo(min_lo),
        .min_hi(min_hi),
        .running(running),
        .rollover(rollover)
    );

    always #10 clock = ~clock;

    typedef struct {
        string       tag;
        logic [17:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  model_sec = 0;
    int  ro_cnt;

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int q;
        m = s / 60;
        q = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(q / 10), 4'(q % 10)};
    endfunction

    task automatic push(input string tag, input logic [17:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [17:0] obs);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [17:0] outs();
        return {running, rollover, min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    // Expect {running, rollover=0, display of a given second count} at the next negedge.
    task automatic expect_disp(input string tag, input logic run, input int secs);
        push(tag, {run, 1'b0, to_bcd(secs)});
        @(negedge clock);
        compare(outs());
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic hz_edge();
        one_hz_in = 1'b1;
        clk_wait(4);
        one_hz_in = 1'b0;
        clk_wait(4);
    endtask

    task automatic press_btn();
        start_stop = 1'b1;
        clk_wait(4);
        start_stop = 1'b0;
        clk_wait(4);
    endtask

    task automatic clear_btn();
        clear = 1'b1;
        clk_wait(4);
        clear = 1'b0;
        clk_wait(4);
    endtask

`ifdef BCD_STOPWATCH_LAP_EN
    task automatic lap_btn();
        lap = 1'b1;
        clk_wait(4);
        lap = 1'b0;
        clk_wait(4);
    endtask
`endif

    initial begin
        reset      = 1'b0;
        one_hz_in  = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
`ifdef BCD_STOPWATCH_LAP_EN
        lap        = 1'b0;
`endif
        @(negedge clock);
        expect_disp("reset_state", 1'b0, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        clk_wait(4);

        // Start, then time the first tick through the synchronizer
        press_btn();
        expect_disp("start_running", 1'b1, 0);
        one_hz_in = 1'b1;
        for (int k = 1; k <= SYNC + 2; k++) begin
            @(posedge clock);
            @(negedge clock);
            push("tick_latency", 18'(k == SYNC + 1));
            compare({17'b0, dut.u_tick_sync.pulse});
            push("digit_latency", {1'b1, 1'b0, to_bcd((k >= SYNC + 2) ? 1 : 0)});
            compare(outs());
        end
        @(posedge clock);
        #1;
        one_hz_in = 1'b0;
        clk_wait(4);
        model_sec = 1;
        repeat (2) hz_edge();
        model_sec += 2;
        expect_disp("count_0003", 1'b1, model_sec);

        // Run up to 59:59 and wrap
        repeat (3596) hz_edge();
        model_sec += 3596;
        expect_disp("preload_5959", 1'b1, model_sec);
        one_hz_in = 1'b1;
        ro_cnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (rollover) ro_cnt++;
        end
        @(posedge clock);
        #1;
        one_hz_in = 1'b0;
        clk_wait(4);
        push("rollover_width", 18'd1);
        compare(18'(ro_cnt));
        model_sec = 0;
        expect_disp("wrap_0000", 1'b1, model_sec);

        // clr and press together: clr wins
        repeat (9) hz_edge();
        model_sec = 9;
        expect_disp("count_0009", 1'b1, model_sec);
        start_stop = 1'b1;
        clear      = 1'b1;
        clk_wait(4);
        start_stop = 1'b0;
        clear      = 1'b0;
        clk_wait(4);
        model_sec = 0;
        expect_disp("clr_beats_press", 1'b0, model_sec);
        hz_edge();
        expect_disp("idle_ignores_tick", 1'b0, model_sec);

        // tick and press together: tick counts, then PAUSE
        press_btn();
        repeat (4) hz_edge();
        model_sec = 4;
        expect_disp("count_0004", 1'b1, model_sec);
        one_hz_in  = 1'b1;
        start_stop = 1'b1;
        clk_wait(4);
        one_hz_in  = 1'b0;
        start_stop = 1'b0;
        clk_wait(4);
        model_sec = 5;
        expect_disp("tick_with_press", 1'b0, model_sec);
        repeat (2) hz_edge();
        expect_disp("pause_frozen", 1'b0, model_sec);
        press_btn();
        hz_edge();
        model_sec = 6;
        expect_disp("resume", 1'b1, model_sec);

        // Reset mid-count overrides everything; held button gives no press
        reset      = 1'b0;
        start_stop = 1'b1;
        one_hz_in  = 1'b1;
        @(posedge clock);
        model_sec = 0;
        expect_disp("reset_priority", 1'b0, model_sec);
        clk_wait(2);
        reset = 1'b1;
        clk_wait(8);
        expect_disp("held_button_idle", 1'b0, model_sec);
        one_hz_in = 1'b0;
        clk_wait(4);
        hz_edge();
        expect_disp("held_button_no_tick", 1'b0, model_sec);
        start_stop = 1'b0;
        clk_wait(4);
        expect_disp("released_idle", 1'b0, model_sec);
        press_btn();
        expect_disp("repress_runs", 1'b1, model_sec);

        // Clear from PAUSE
        repeat (2) hz_edge();
        model_sec = 2;
        press_btn();
        expect_disp("paused_0002", 1'b0, model_sec);
        clear_btn();
        model_sec = 0;
        expect_disp("clr_from_pause", 1'b0, model_sec);

`ifdef BCD_STOPWATCH_LAP_EN
        press_btn();
        repeat (2) hz_edge();
        model_sec = 2;
        expect_disp("lap_at_0002", 1'b1, model_sec);
        lap_btn();
        repeat (5) hz_edge();
        model_sec = 7;
        expect_disp("lap_frozen", 1'b1, 2);
        lap_btn();
        expect_disp("lap_live", 1'b1, model_sec);
        lap_btn();
        hz_edge();
        model_sec = 8;
        expect_disp("lap_frozen_again", 1'b1, 7);
        clear_btn();
        model_sec = 0;
        expect_disp("clr_releases_lap", 1'b0, model_sec);
        press_btn();
        hz_edge();
        model_sec = 1;
        expect_disp("live_after_clr", 1'b1, model_sec);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
